// File: rtl/mesi_pkg.sv
// Encodings shared by the MESI cache slice controller: line states, trace
// commands, snoop responses, bus operations and the sequencer FSM states.
package mesi_pkg;

   typedef enum logic [1:0] {
      ST_M = 2'b00,
      ST_E = 2'b01,
      ST_S = 2'b10,
      ST_I = 2'b11
   } line_st_e;

   typedef enum logic [3:0] {
      CMD_READ      = 4'd0,
      CMD_WRITE     = 4'd1,
      CMD_IREAD     = 4'd2,
      CMD_SNP_INV   = 4'd3,
      CMD_SNP_READ  = 4'd4,
      CMD_SNP_WRITE = 4'd5,
      CMD_SNP_RFO   = 4'd6,
      CMD_CLEAR     = 4'd8,
      CMD_PRINT     = 4'd9
   } cmd_e;

   typedef enum logic [1:0] {
      RSP_NOHIT = 2'b00,
      RSP_HIT   = 2'b01,
      RSP_HITM  = 2'b10
   } snp_rsp_e;

   typedef enum logic [1:0] {
      BUS_READ  = 2'b00,
      BUS_WRITE = 2'b01,
      BUS_INV   = 2'b10,
      BUS_RFO   = 2'b11
   } bus_op_e;

   typedef enum logic [2:0] {
      F_IDLE,
      F_LOOKUP,
      F_EVICT,
      F_BUS,
      F_SNP_WB,
      F_PRINT
   } fsm_e;

endpackage

// File: rtl/mesi_next_state.sv
// MESI transition table: effective line state (I on a tag miss), command and
// bus snoop result in; next line state, snoop response and required bus op out.
module mesi_next_state
   import mesi_pkg::*;
(
   input  line_st_e   cur_i,
   input  logic [3:0] cmd_i,
   input  logic [1:0] snp_res_i,
   output line_st_e   nxt_o,
   output snp_rsp_e   rsp_o,
   output logic       bus_need_o,
   output bus_op_e    bus_op_o
);

   always_comb begin
      nxt_o      = cur_i;
      rsp_o      = RSP_NOHIT;
      bus_need_o = 1'b0;
      bus_op_o   = BUS_READ;
      case (cmd_i)
         CMD_READ, CMD_IREAD: begin
            if (cur_i == ST_I) begin
               bus_need_o = 1'b1;
               bus_op_o   = BUS_READ;
               nxt_o      = (snp_res_i == RSP_HIT || snp_res_i == RSP_HITM) ? ST_S : ST_E;
            end
         end
         CMD_WRITE: begin
            nxt_o = ST_M;
            if (cur_i == ST_S) begin
               bus_need_o = 1'b1;
               bus_op_o   = BUS_INV;
            end else if (cur_i == ST_I) begin
               bus_need_o = 1'b1;
               bus_op_o   = BUS_RFO;
            end
         end
         CMD_SNP_READ, CMD_SNP_RFO: begin
            // Only a dirty owner has to push the line back before giving it up.
            if (cur_i != ST_I) begin
               rsp_o      = (cur_i == ST_M) ? RSP_HITM : RSP_HIT;
               bus_need_o = (cur_i == ST_M);
               bus_op_o   = BUS_WRITE;
               nxt_o      = (cmd_i == CMD_SNP_READ) ? ST_S : ST_I;
            end
         end
         CMD_SNP_INV: begin
            if (cur_i == ST_S) nxt_o = ST_I;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mesi_cache_ctrl.sv
// Command sequencer for one L2 slice: tag lookup, victim writeback, bus
// handshakes, MESI updates of a direct-mapped tag/state array, print and stats.
module mesi_cache_ctrl
   import mesi_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int SET_BITS  = 6,
   parameter int LINE_BITS = 6
)(
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  cmd_valid,
   output logic                                  cmd_ready,
   input  logic [3:0]                            cmd,
   input  logic [ADDR_W-1:0]                     cmd_addr,
   output logic                                  bus_req,
   output logic [1:0]                            bus_op,
   output logic [ADDR_W-1:0]                     bus_addr,
   input  logic                                  bus_gnt,
   input  logic [1:0]                            bus_snoop_result,
   output logic                                  snoop_resp_valid,
   output logic [1:0]                            snoop_resp,
   output logic                                  dump_valid,
   output logic [SET_BITS-1:0]                   dump_set,
   output logic [ADDR_W-SET_BITS-LINE_BITS-1:0]  dump_tag,
   output logic [1:0]                            dump_state,
   output logic [31:0]                           hit_cnt,
   output logic [31:0]                           miss_cnt,
   output logic [31:0]                           read_cnt,
   output logic [31:0]                           write_cnt
);

   localparam int TAG_W = ADDR_W - SET_BITS - LINE_BITS;
   localparam int LA_W  = ADDR_W - LINE_BITS;
   localparam int SETS  = 1 << SET_BITS;

   fsm_e                fsm_q, fsm_d;
   logic [3:0]          cmd_q;
   logic [LA_W-1:0]     la_q;
   line_st_e            cur_q, cur_d;
   bus_op_e             pend_q, pend_d;
   bus_op_e             bus_op_q, bus_op_d;
   logic [LA_W-1:0]     bus_la_q, bus_la_d;
   logic                rsp_vld_q, rsp_vld_d;
   snp_rsp_e            rsp_q, rsp_d;
   logic [SET_BITS-1:0] ptr_q, ptr_d;
   logic                dmp_vld_q, dmp_vld_d;
   logic [SET_BITS-1:0] dmp_set_q, dmp_set_d;
   logic [TAG_W-1:0]    dmp_tag_q, dmp_tag_d;
   line_st_e            dmp_st_q, dmp_st_d;
   logic [31:0]         hit_q, hit_d, miss_q, miss_d, rd_q, rd_d, wr_q, wr_d;

   line_st_e            st_q  [SETS];
   logic [TAG_W-1:0]    tag_q [SETS];
   logic                arr_we, arr_clr;

   logic [SET_BITS-1:0] idx;
   logic [TAG_W-1:0]    ltag;
   logic                hit;
   line_st_e            eff, ns_cur, ns_nxt;
   snp_rsp_e            ns_rsp;
   logic                ns_need;
   bus_op_e             ns_op;
   logic                unused_ofs;

   assign unused_ofs = ^cmd_addr[LINE_BITS-1:0];
   assign idx        = la_q[SET_BITS-1:0];
   assign ltag       = la_q[LA_W-1:SET_BITS];
   assign hit        = (tag_q[idx] == ltag) && (st_q[idx] != ST_I);
   assign eff        = hit ? st_q[idx] : ST_I;
   // During a fill the table must see the state captured at lookup, not the array.
   assign ns_cur     = (fsm_q == F_BUS) ? cur_q : eff;

   mesi_next_state u_ns (
      .cur_i      (ns_cur),
      .cmd_i      (cmd_q),
      .snp_res_i  (bus_snoop_result),
      .nxt_o      (ns_nxt),
      .rsp_o      (ns_rsp),
      .bus_need_o (ns_need),
      .bus_op_o   (ns_op)
   );

   assign cmd_ready        = (fsm_q == F_IDLE);
   assign bus_req          = (fsm_q == F_EVICT) || (fsm_q == F_BUS) || (fsm_q == F_SNP_WB);
   assign bus_op           = bus_op_q;
   assign bus_addr         = {bus_la_q, {LINE_BITS{1'b0}}};
   assign snoop_resp_valid = rsp_vld_q;
   assign snoop_resp       = rsp_q;
   assign dump_valid       = dmp_vld_q;
   assign dump_set         = dmp_set_q;
   assign dump_tag         = dmp_tag_q;
   assign dump_state       = dmp_st_q;
   assign hit_cnt          = hit_q;
   assign miss_cnt         = miss_q;
   assign read_cnt         = rd_q;
   assign write_cnt        = wr_q;

   always_comb begin
      fsm_d     = fsm_q;
      cur_d     = cur_q;
      pend_d    = pend_q;
      bus_op_d  = bus_op_q;
      bus_la_d  = bus_la_q;
      rsp_vld_d = 1'b0;
      rsp_d     = rsp_q;
      ptr_d     = ptr_q;
      dmp_vld_d = 1'b0;
      dmp_set_d = dmp_set_q;
      dmp_tag_d = dmp_tag_q;
      dmp_st_d  = dmp_st_q;
      hit_d     = hit_q;
      miss_d    = miss_q;
      rd_d      = rd_q;
      wr_d      = wr_q;
      arr_we    = 1'b0;
      arr_clr   = 1'b0;
      case (fsm_q)
         F_IDLE: begin
            if (cmd_valid) fsm_d = F_LOOKUP;
         end
         F_LOOKUP: begin
            fsm_d = F_IDLE;
            cur_d = eff;
            case (cmd_q)
               CMD_READ, CMD_IREAD, CMD_WRITE: begin
                  if (cmd_q == CMD_WRITE) wr_d = wr_q + 32'd1;
                  else                    rd_d = rd_q + 32'd1;
                  if (hit) hit_d  = hit_q + 32'd1;
                  else     miss_d = miss_q + 32'd1;
                  if (!ns_need) begin
                     arr_we = 1'b1;
                  end else if (!hit && st_q[idx] == ST_M) begin
                     // Dirty victim goes out first; the fill op waits in pend_q.
                     fsm_d    = F_EVICT;
                     bus_op_d = BUS_WRITE;
                     bus_la_d = {tag_q[idx], idx};
                     pend_d   = ns_op;
                  end else begin
                     fsm_d    = F_BUS;
                     bus_op_d = ns_op;
                     bus_la_d = la_q;
                  end
               end
               CMD_SNP_INV, CMD_SNP_READ, CMD_SNP_WRITE, CMD_SNP_RFO: begin
                  rsp_vld_d = 1'b1;
                  rsp_d     = ns_rsp;
                  arr_we    = hit;
                  if (ns_need) begin
                     fsm_d    = F_SNP_WB;
                     bus_op_d = BUS_WRITE;
                     bus_la_d = la_q;
                  end
               end
               CMD_CLEAR: begin
                  arr_clr = 1'b1;
                  hit_d   = '0;
                  miss_d  = '0;
                  rd_d    = '0;
                  wr_d    = '0;
               end
               CMD_PRINT: begin
                  fsm_d = F_PRINT;
                  ptr_d = '0;
               end
               default: ;
            endcase
         end
         F_EVICT: begin
            if (bus_gnt) begin
               fsm_d    = F_BUS;
               bus_op_d = pend_q;
               bus_la_d = la_q;
            end
         end
         F_BUS: begin
            if (bus_gnt) begin
               fsm_d  = F_IDLE;
               arr_we = 1'b1;
            end
         end
         F_SNP_WB: begin
            if (bus_gnt) fsm_d = F_IDLE;
         end
         F_PRINT: begin
            dmp_vld_d = (st_q[ptr_q] != ST_I);
            dmp_set_d = ptr_q;
            dmp_tag_d = tag_q[ptr_q];
            dmp_st_d  = st_q[ptr_q];
            ptr_d     = ptr_q + SET_BITS'(1);
            if (&ptr_q) fsm_d = F_IDLE;
         end
         default: fsm_d = F_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q     <= F_IDLE;
         cmd_q     <= '0;
         la_q      <= '0;
         cur_q     <= ST_I;
         pend_q    <= BUS_READ;
         bus_op_q  <= BUS_READ;
         bus_la_q  <= '0;
         rsp_vld_q <= 1'b0;
         rsp_q     <= RSP_NOHIT;
         ptr_q     <= '0;
         dmp_vld_q <= 1'b0;
         dmp_set_q <= '0;
         dmp_tag_q <= '0;
         dmp_st_q  <= ST_M;
         hit_q     <= '0;
         miss_q    <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
      end else begin
         fsm_q     <= fsm_d;
         if (fsm_q == F_IDLE && cmd_valid) begin
            cmd_q <= cmd;
            la_q  <= cmd_addr[ADDR_W-1:LINE_BITS];
         end
         cur_q     <= cur_d;
         pend_q    <= pend_d;
         bus_op_q  <= bus_op_d;
         bus_la_q  <= bus_la_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_q     <= rsp_d;
         ptr_q     <= ptr_d;
         dmp_vld_q <= dmp_vld_d;
         dmp_set_q <= dmp_set_d;
         dmp_tag_q <= dmp_tag_d;
         dmp_st_q  <= dmp_st_d;
         hit_q     <= hit_d;
         miss_q    <= miss_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SETS; i++) begin
            st_q[i]  <= ST_I;
            tag_q[i] <= '0;
         end
      end else if (arr_clr) begin
         for (int i = 0; i < SETS; i++) st_q[i] <= ST_I;
      end else if (arr_we) begin
         st_q[idx]  <= ns_nxt;
         tag_q[idx] <= ltag;
      end
   end

endmodule

// File: tb/tb_mesi_cache_ctrl.sv
// Directed bench for mesi_cache_ctrl: scripted commands, a delay-programmable
// bus responder, and monitors for snoop responses and print dumps.
module tb_mesi_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd = 4'd0;
   logic [31:0] cmd_addr = 32'd0;
   logic        bus_req;
   logic [1:0]  bus_op;
   logic [31:0] bus_addr;
   logic        bus_gnt = 1'b0;
   logic [1:0]  bus_snoop_result = 2'b00;
   logic        snoop_resp_valid;
   logic [1:0]  snoop_resp;
   logic        dump_valid;
   logic [5:0]  dump_set;
   logic [19:0] dump_tag;
   logic [1:0]  dump_state;
   logic [31:0] hit_cnt, miss_cnt, read_cnt, write_cnt;

   mesi_cache_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd              (cmd),
      .cmd_addr         (cmd_addr),
      .bus_req          (bus_req),
      .bus_op           (bus_op),
      .bus_addr         (bus_addr),
      .bus_gnt          (bus_gnt),
      .bus_snoop_result (bus_snoop_result),
      .snoop_resp_valid (snoop_resp_valid),
      .snoop_resp       (snoop_resp),
      .dump_valid       (dump_valid),
      .dump_set         (dump_set),
      .dump_tag         (dump_tag),
      .dump_state       (dump_state),
      .hit_cnt          (hit_cnt),
      .miss_cnt         (miss_cnt),
      .read_cnt         (read_cnt),
      .write_cnt        (write_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bus responder: grants after gnt_dly waiting cycles, logs every completed op.
   int          gnt_dly = 0;
   logic [1:0]  snp_res = 2'b00;
   int          wait_n  = 0;
   int          n_ops   = 0;
   logic [1:0]  log_op   [32];
   logic [31:0] log_addr [32];
   logic [1:0]  cap_op;
   logic [31:0] cap_addr;

   initial begin
      forever begin
         @(negedge clk);
         bus_gnt = 1'b0;
         if (bus_req) begin
            if (wait_n == 0) begin
               cap_op   = bus_op;
               cap_addr = bus_addr;
            end else begin
               chk("bus_op_hold", bus_op, cap_op);
               chk("bus_addr_hold", bus_addr, cap_addr);
            end
            if (wait_n >= gnt_dly) begin
               if (n_ops < 32) begin
                  log_op[n_ops]   = bus_op;
                  log_addr[n_ops] = bus_addr;
               end
               n_ops++;
               bus_gnt          = 1'b1;
               bus_snoop_result = snp_res;
               wait_n           = 0;
            end else begin
               wait_n++;
            end
         end else begin
            wait_n = 0;
         end
      end
   end

   int          n_snp = 0;
   logic [1:0]  last_snp = 2'b11;
   int          n_dmp = 0;
   logic [5:0]  d_set [8];
   logic [19:0] d_tag [8];
   logic [1:0]  d_st  [8];

   initial begin
      forever begin
         @(negedge clk);
         if (snoop_resp_valid) begin
            n_snp++;
            last_snp = snoop_resp;
         end
         if (dump_valid) begin
            if (n_dmp < 8) begin
               d_set[n_dmp] = dump_set;
               d_tag[n_dmp] = dump_tag;
               d_st[n_dmp]  = dump_state;
            end
            n_dmp++;
         end
      end
   end

   // Latency = negedges from the accept edge until cmd_ready is seen high again.
   task automatic issue(input logic [3:0] c, input logic [31:0] a, output int lat);
      cmd       = c;
      cmd_addr  = a;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!cmd_ready && lat < 300);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int h, input int m, input int r, input int w);
      chk({tag, "_hit"},   hit_cnt,   h);
      chk({tag, "_miss"},  miss_cnt,  m);
      chk({tag, "_read"},  read_cnt,  r);
      chk({tag, "_write"}, write_cnt, w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int s0;

      @(negedge clk);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_bus_req", bus_req, 0);
      chk("rst_bus_op", bus_op, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_snp_vld", snoop_resp_valid, 0);
      chk("rst_snp", snoop_resp, 0);
      chk("rst_dump_vld", dump_valid, 0);
      chk("rst_dump", {dump_set, dump_tag, dump_state}, 0);
      chk_cnt("rst", 0, 0, 0, 0);
      rst = 1'b0;
      @(negedge clk);

      // Cold read miss, grant immediately, noHIT -> E
      gnt_dly = 0;
      snp_res = 2'b00;
      issue(4'd0, 32'h0000_1040, lat);
      chk("rd_miss_lat", lat, 3);
      chk("rd_miss_nops", n_ops, 1);
      chk("rd_miss_op", log_op[0], 2'b00);
      chk("rd_miss_addr", log_addr[0], 32'h0000_1040);
      chk_cnt("rd_miss", 0, 1, 1, 0);

      issue(4'd0, 32'h0000_1040, lat);
      chk("rd_hit_lat", lat, 2);
      chk("rd_hit_nops", n_ops, 1);
      chk_cnt("rd_hit", 1, 1, 2, 0);

      // Write hit in E -> M silently
      issue(4'd1, 32'h0000_1040, lat);
      chk("wr_e_lat", lat, 2);
      chk("wr_e_nops", n_ops, 1);
      chk_cnt("wr_e", 2, 1, 2, 1);

      // Conflicting write: evict dirty victim then RFO, grants delayed 3 cycles
      gnt_dly = 3;
      issue(4'd1, 32'h8000_1040, lat);
      chk("wr_ev_lat", lat, 10);
      chk("wr_ev_nops", n_ops, 3);
      chk("wr_ev_op0", log_op[1], 2'b01);
      chk("wr_ev_addr0", log_addr[1], 32'h0000_1040);
      chk("wr_ev_op1", log_op[2], 2'b11);
      chk("wr_ev_addr1", log_addr[2], 32'h8000_1040);
      chk_cnt("wr_ev", 2, 2, 2, 2);

      // Snoop read on M: HITM, writeback, -> S
      gnt_dly = 0;
      s0 = n_snp;
      issue(4'd4, 32'h8000_1040, lat);
      chk("snp_rd_lat", lat, 3);
      chk("snp_rd_cnt", n_snp, s0 + 1);
      chk("snp_rd_rsp", last_snp, 2'b10);
      chk("snp_rd_nops", n_ops, 4);
      chk("snp_rd_op", log_op[3], 2'b01);
      chk("snp_rd_addr", log_addr[3], 32'h8000_1040);
      chk_cnt("snp_rd", 2, 2, 2, 2);

      n_dmp = 0;
      issue(4'd9, 32'h0, lat);
      chk("prt1_lat", lat, 66);
      chk("prt1_n", n_dmp, 1);
      chk("prt1_set", d_set[0], 6'd1);
      chk("prt1_tag", d_tag[0], 20'h80001);
      chk("prt1_st", d_st[0], 2'b10);

      issue(4'd3, 32'h8000_1040, lat);
      chk("snp_inv_lat", lat, 2);
      chk("snp_inv_cnt", n_snp, s0 + 2);
      chk("snp_inv_rsp", last_snp, 2'b00);

      // Line now invalid: a snoop read misses with no writeback
      issue(4'd4, 32'h8000_1040, lat);
      chk("snp_miss_lat", lat, 2);
      chk("snp_miss_cnt", n_snp, s0 + 3);
      chk("snp_miss_rsp", last_snp, 2'b00);
      chk("snp_miss_nops", n_ops, 4);

      // Two fills: one shared (HIT), one exclusive (inst read, noHIT)
      snp_res = 2'b01;
      issue(4'd0, 32'h0000_0080, lat);
      chk("fill_s_lat", lat, 3);
      snp_res = 2'b00;
      issue(4'd2, 32'h0003_0FC0, lat);
      chk("fill_e_lat", lat, 3);
      chk("fill_nops", n_ops, 6);
      chk("fill_e_addr", log_addr[5], 32'h0003_0FC0);
      chk_cnt("fill", 2, 4, 4, 2);

      issue(4'd7, 32'h0000_0080, lat);
      chk("undef_lat", lat, 2);
      chk("undef_snp", n_snp, s0 + 3);
      chk_cnt("undef", 2, 4, 4, 2);

      n_dmp = 0;
      issue(4'd9, 32'h0, lat);
      chk("prt2_lat", lat, 66);
      chk("prt2_n", n_dmp, 2);
      chk("prt2_set0", d_set[0], 6'd2);
      chk("prt2_tag0", d_tag[0], 20'h00000);
      chk("prt2_st0", d_st[0], 2'b10);
      chk("prt2_set1", d_set[1], 6'd63);
      chk("prt2_tag1", d_tag[1], 20'h00030);
      chk("prt2_st1", d_st[1], 2'b01);

      issue(4'd8, 32'h0, lat);
      chk("clr_lat", lat, 2);
      chk_cnt("clr", 0, 0, 0, 0);
      n_dmp = 0;
      issue(4'd9, 32'h0, lat);
      chk("prt3_n", n_dmp, 0);

      // Reset while waiting for a grant that never comes
      issue(4'd0, 32'h0000_0080, lat);
      chk("pre_rst_lat", lat, 3);
      gnt_dly   = 1000;
      cmd       = 4'd0;
      cmd_addr  = 32'h0000_2040;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_req", bus_req, 1);
      chk("pre_rst_addr", bus_addr, 32'h0000_2040);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_req", bus_req, 0);
      chk("rst_mid_ready", cmd_ready, 1);
      chk_cnt("rst_mid", 0, 0, 0, 0);
      @(negedge clk);
      rst     = 1'b0;
      gnt_dly = 0;
      @(negedge clk);
      chk("rst_mid_nops", n_ops, 7);
      n_dmp = 0;
      issue(4'd9, 32'h0, lat);
      chk("prt4_lat", lat, 66);
      chk("prt4_n", n_dmp, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
